// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: shared constants and types for the interrupt controller
package int_ctrl_pkg;
  localparam int INT_LINES = 6;
  localparam int TIMER_LINE = 5;
  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;
  typedef logic [INT_LINES-1:0] line_vec_t;
  function automatic line_vec_t rise_vec(line_vec_t s, line_vec_t p);
    return s & ~p;
  endfunction
endpackage

// File: rtl/int_sync.sv
// int_sync: multi-flop synchronizer for one interrupt line with previous-sample output
module int_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic s,
  output logic prev
);
  logic [SYNC_STAGES-1:0] ff;
  always_ff @(posedge clk) begin
    if (rst) begin
      ff <= '0;
      prev <= 1'b0;
    end else begin
      ff <= {ff[SYNC_STAGES-2:0], d};
      prev <= ff[SYNC_STAGES-1];
    end
  end
  assign s = ff[SYNC_STAGES-1];
endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: level/edge interrupt controller with optional count/compare timer on line 5 (INT_CTRL_TIMER_EN)
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_DIV = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INT_LINES-1:0] irq_in,
  input  logic [INT_LINES-1:0] irq_edge,
  input  logic                 ack,
  input  logic [INT_LINES-1:0] ack_mask,
  input  logic                 cnt_wr,
  input  logic                 cmp_wr,
  input  logic [31:0]          wr_data,
  output logic [31:0]          count,
  output logic [31:0]          compare,
  output logic [INT_LINES-1:0] hard_int,
  output logic                 timer_pending
);
  line_vec_t s, prev, pending, pend_nxt, rise, clr, hi_nxt, tp_bits;
  logic [2:0] warm;
  logic armed;
  for (genvar i = 0; i < INT_LINES; i++) begin : g_sync
    int_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk(clk), .rst(rst), .d(irq_in[i]), .s(s[i]), .prev(prev[i])
    );
  end
  // Edges are ignored until both s and prev hold post-reset samples, so lines high through reset never latch
  assign armed = warm == 3'(SYNC_STAGES + 1);
  assign rise = armed ? rise_vec(s, prev) : '0;
  assign clr = ack ? ack_mask : '0;
  assign pend_nxt = irq_edge & (rise | (pending & ~clr));
`ifdef INT_CTRL_TIMER_EN
  localparam line_vec_t LINE_MASK = ~(line_vec_t'(1) << TIMER_LINE);
  localparam int PW = COUNT_DIV > 1 ? $clog2(COUNT_DIV) : 1;
  logic [PW-1:0] pre;
  logic inc, upd, tp_nxt;
  logic [31:0] cnt_nxt;
  assign inc = pre == PW'(COUNT_DIV - 1);
  assign cnt_nxt = cnt_wr ? wr_data : count + 32'(inc);
  assign upd = cnt_wr | inc;
  // Match compares against the old compare value; a compare write always clears
  assign tp_nxt = !cmp_wr && (timer_pending || (upd && cnt_nxt == compare));
  assign tp_bits = line_vec_t'(tp_nxt) << TIMER_LINE;
  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
      count <= '0;
      compare <= COMPARE_RST;
      timer_pending <= 1'b0;
    end else begin
      pre <= upd ? '0 : pre + 1'b1;
      count <= cnt_nxt;
      compare <= cmp_wr ? wr_data : compare;
      timer_pending <= tp_nxt;
    end
  end
`else
  localparam line_vec_t LINE_MASK = '1;
  logic unused_timer;
  assign unused_timer = ^{cnt_wr, cmp_wr, wr_data};
  assign tp_bits = '0;
  assign count = '0;
  assign compare = '0;
  assign timer_pending = 1'b0;
`endif
  assign hi_nxt = LINE_MASK & (pend_nxt | (~irq_edge & s));
  always_ff @(posedge clk) begin
    if (rst) begin
      warm <= '0;
      pending <= '0;
      hard_int <= '0;
    end else begin
      warm <= armed ? warm : warm + 3'd1;
      pending <= pend_nxt & LINE_MASK;
      hard_int <= hi_nxt | tp_bits;
    end
  end
endmodule
